// File: rtl/full_dmrf_alu.sv
// full_dmrf_alu: single-cycle register file, ALU and data-memory slice producing the branch Zero flag; define DMRF_DEBUG_PORTS_EN to expose alu_result, wb_data and mem_rdata.
module full_dmrf_alu #(
    parameter int DM_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] SEin,
    input  logic [5:0]  FuncCode,
    input  logic        Regsel,
    input  logic        ALUsel,
    input  logic [1:0]  ALUOp,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemToRegSel,
    input  logic        RegWrite,
`ifdef DMRF_DEBUG_PORTS_EN
    output logic [31:0] alu_result,
    output logic [31:0] wb_data,
    output logic [31:0] mem_rdata,
`endif
    output logic        Zero
);
    logic [31:0] r_regs [32];
    logic [31:0] r_mem [2**DM_ADDR_W] = '{default: '0};
    logic [31:0] w_a, w_rt, w_b, w_imm, w_alu, w_rdata, w_wb;
    logic [4:0]  w_waddr;
    logic [DM_ADDR_W-1:0] w_maddr;
    logic        w_unused;
    assign w_a     = rs == 5'd0 ? 32'd0 : r_regs[rs];
    assign w_rt    = rt == 5'd0 ? 32'd0 : r_regs[rt];
    assign w_imm   = {{16{SEin[15]}}, SEin};
    assign w_b     = ALUsel ? w_imm : w_rt;
    assign w_waddr = Regsel ? rd : rt;
    assign w_maddr = w_alu[DM_ADDR_W+1:2];
    assign w_rdata = MemRead ? r_mem[w_maddr] : 32'd0;
    assign w_wb    = MemToRegSel ? w_rdata : w_alu;
    assign Zero    = w_alu == 32'd0;
    assign w_unused = ^{FuncCode[5:4], w_alu};
    always_comb begin
        w_alu = w_a + w_b;
        if (ALUOp == 2'b01)
            w_alu = w_a - w_b;
        else if (ALUOp == 2'b11)
            w_alu = w_a | w_b;
        else if (ALUOp == 2'b10) begin
            case (FuncCode[3:0])
                4'b0010: w_alu = w_a - w_b;
                4'b0100: w_alu = w_a & w_b;
                4'b0101: w_alu = w_a | w_b;
                4'b0111: w_alu = ~(w_a | w_b);
                4'b1010: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
                default: w_alu = w_a + w_b;
            endcase
        end
    end
    // Register 0 is never written, so it holds its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        else if (RegWrite && w_waddr != 5'd0)
            r_regs[w_waddr] <= w_wb;
    end
    always_ff @(posedge clk) begin
        if (MemWrite) r_mem[w_maddr] <= w_rt;
    end
`ifdef DMRF_DEBUG_PORTS_EN
    assign alu_result = w_alu;
    assign wb_data    = w_wb;
    assign mem_rdata  = w_rdata;
`endif
endmodule

// File: tb/tb_full_dmrf_alu.sv
// tb_full_dmrf_alu: randomized and directed checks of full_dmrf_alu's Zero flag against an array-based reference model.
module tb_full_dmrf_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [5:0]  FuncCode;
    logic        Regsel, ALUsel, MemWrite, MemRead, MemToRegSel, RegWrite;
    logic [1:0]  ALUOp;
    logic        Zero;
`ifdef DMRF_DEBUG_PORTS_EN
    logic [31:0] alu_result, wb_data, mem_rdata;
`endif
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_r [32];
    logic [31:0] m_mem [256];

    full_dmrf_alu dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd), .SEin(SEin),
        .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel), .ALUOp(ALUOp),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToRegSel(MemToRegSel),
        .RegWrite(RegWrite),
`ifdef DMRF_DEBUG_PORTS_EN
        .alu_result(alu_result), .wb_data(wb_data), .mem_rdata(mem_rdata),
`endif
        .Zero(Zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic [5:0] fc);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        case (fc[3:0])
            4'd2:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd7:  return ~(a | b);
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: Zero=%b expected %b", tag, got, exp);
    endtask

    // want < 0: model only; otherwise Zero must also equal the hand-derived constant
    task automatic cycle(input string tag, input int want);
        logic [31:0] a, b, res, rdat, wb;
        logic [4:0]  wa;
        #1;
        a   = m_r[rs];
        b   = ALUsel ? {{16{SEin[15]}}, SEin} : m_r[rt];
        res = ref_alu(a, b, ALUOp, FuncCode);
        check(tag, Zero, res == 32'd0);
        if (want >= 0) check({tag, "_const"}, Zero, want[0]);
        rdat = MemRead ? m_mem[res[9:2]] : 32'd0;
        wb   = MemToRegSel ? rdat : res;
        wa   = Regsel ? rd : rt;
        @(posedge clk);
        if (MemWrite) m_mem[res[9:2]] = m_r[rt];
        if (!rst_n) m_r = '{default: 32'd0};
        else if (RegWrite && wa != 5'd0) m_r[wa] = wb;
        @(negedge clk);
    endtask

    task automatic idle();
        rs = 0; rt = 0; rd = 0; SEin = 0; FuncCode = 0; Regsel = 0; ALUsel = 0;
        ALUOp = 0; MemWrite = 0; MemRead = 0; MemToRegSel = 0; RegWrite = 0;
    endtask

    task automatic load_imm(input logic [4:0] dst, input logic [15:0] imm);
        idle();
        rt = dst; SEin = imm; ALUsel = 1; RegWrite = 1;
        cycle("load_imm", -1);
    endtask

    initial begin
        logic [3:0] codes [6];
        logic [31:0] rv;
        codes = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd10};
        m_r = '{default: 32'd0};
        m_mem = '{default: 32'd0};
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rs = 1; rt = 2;
        cycle("reset_zero", 1);
        rst_n = 1;
        @(negedge clk);
        cycle("after_release", 1);

        load_imm(5, 16'h0014);
        idle(); rs = 5; rt = 5; ALUOp = 2'b10; FuncCode = 6'b000010;
        cycle("sub_self", 1);
        idle(); SEin = 16'hFFEC; ALUsel = 1;
        cycle("neg_imm", 0);
        idle(); rs = 5; SEin = 16'hFFEC; ALUsel = 1; ALUOp = 2'b10; FuncCode = 6'b001010;
        cycle("slt_neg", 1);
        idle(); rs = 5; SEin = 16'hFFEC; ALUsel = 1; ALUOp = 2'b01;
        cycle("sub_neg", 0);

        load_imm(6, 16'h5555);
        for (int i = 0; i < 16; i++) begin
            idle(); rs = 6; rt = 6; RegWrite = 1;
            cycle("double", -1);
        end
        idle(); rs = 6; rt = 6; SEin = 16'h5555; ALUsel = 1; ALUOp = 2'b11; RegWrite = 1;
        cycle("or_imm", -1);
        idle(); rs = 5; rt = 6; ALUsel = 1; MemWrite = 1;
        cycle("mem_store", 0);
        idle(); rs = 5; ALUsel = 1; MemRead = 1; MemToRegSel = 1; RegWrite = 1; Regsel = 1; rd = 7;
        cycle("mem_load", 0);
        idle(); rs = 7; rt = 6; ALUOp = 2'b01;
        cycle("load_eq", 1);
        idle(); rs = 6; SEin = 16'h5555; ALUsel = 1; ALUOp = 2'b10; FuncCode = 6'b110111;
        cycle("nor_big", 0);
        idle(); rs = 5; SEin = 16'hFFEC; ALUsel = 1; ALUOp = 2'b10; FuncCode = 6'b111000;
        cycle("undef_add", 1);

        idle(); SEin = 16'h0014; ALUsel = 1; Regsel = 1; rd = 0; RegWrite = 1;
        cycle("r0_write", 0);
        idle(); ALUsel = 1;
        cycle("r0_read", 1);

        for (int n = 0; n < 400; n++) begin
            idle();
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
            SEin = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8) - 4);
            FuncCode = 6'($urandom);
            if ($urandom_range(0, 3) != 0) FuncCode[3:0] = codes[$urandom_range(0, 5)];
            ALUOp = 2'($urandom); ALUsel = 1'($urandom); Regsel = 1'($urandom);
            MemWrite = $urandom_range(0, 3) == 0; MemRead = 1'($urandom);
            MemToRegSel = 1'($urandom); RegWrite = $urandom_range(0, 3) != 0;
            cycle("random", -1);
        end

        load_imm(31, 16'h0001);
        for (int b = 0; b < 32; b++) begin
            for (int i = 1; i < 8; i++) begin
                idle(); rs = 5'(i); rt = 31; ALUOp = 2'b10; FuncCode = 6'b000100;
                cycle("bit_probe", -1);
            end
            idle(); rs = 31; rt = 31; RegWrite = 1;
            cycle("mask_shift", -1);
        end

        load_imm(1, 16'h0007);
        load_imm(2, 16'h0003);
        idle(); rs = 1; rt = 2; RegWrite = 1;
        #2 rst_n = 0;
        m_r = '{default: 32'd0};
        #1 check("async_clear", Zero, 1'b1);
        cycle("reset_held", 1);
        idle(); rt = 3; SEin = 16'h0005; ALUsel = 1; RegWrite = 1;
        cycle("reset_nowrite", 0);
        rst_n = 1;
        idle(); rs = 3; ALUsel = 1;
        cycle("reg3_clear", 1);
        idle(); rs = 1; rt = 2;
        cycle("regs_clear", 1);
        rv = m_r[7];
        check("model_r7", rv == 32'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/full_dmrf_alu.md
Name: full_dmrf_alu

Overview:
Single-cycle MIPS-style execute/memory/write-back slice. It combines a 32x32 register file, a sign-extender, an ALU with operation decode, and a word-addressed data memory. The control decoder (not part of this block) drives the control inputs. The only architectural output is the ALU Zero flag, used by the branch logic.

Parameters:
DM_ADDR_W, 8, data-memory word-address width (depth = 2**DM_ADDR_W words of 32 bits).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rs  input  5  register-file read address A.
rt  input  5  register-file read address B; default write address.
rd  input  5  alternate write address.
SEin  input  16  immediate, sign-extended to 32 bits.
FuncCode  input  6  R-type function field.
Regsel  input  1  write-address select: 1 = rd, 0 = rt.
ALUsel  input  1  ALU B-operand select: 1 = sign-extended immediate, 0 = reg[rt].
ALUOp  input  2  ALU operation class.
MemWrite  input  1  data-memory write enable.
MemRead  input  1  data-memory read enable.
MemToRegSel  input  1  write-back select: 1 = memory data, 0 = ALU result.
RegWrite  input  1  register-file write enable.
Zero  output  1  high when the ALU result equals 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Register file: 32 x 32 bits.
  - Two combinational reads: A = reg[rs], B = reg[rt].
  - Register 0 always reads 0; writes to it are discarded.
  - Write at posedge clk when RegWrite=1. Address = Regsel ? rd : rt. Data = write-back value.
- Sign extension: imm32 = {16{SEin[15]}, SEin}.
- ALU inputs: operand A = reg[rs]; operand B = ALUsel ? imm32 : reg[rt].
- ALU operation from ALUOp:
  - 00: add.
  - 01: subtract.
  - 11: or.
  - 10: decode FuncCode[3:0]; FuncCode[5:4] are ignored. 0000 add, 0010 sub, 0100 and, 0101 or, 0111 nor, 1010 set-less-than signed (result 1 or 0). Any other code performs add.
- Arithmetic is 32-bit modulo 2^32; overflow is ignored and there is no exception.
- Zero = (alu_result == 0). Purely combinational, so it has zero latency from its inputs.
- Data memory:
  - Word address = alu_result[DM_ADDR_W+1:2]; the upper address bits and the byte offset are ignored, so addresses wrap.
  - Write at posedge clk when MemWrite=1, data = reg[rt].
  - Read is combinational: mem[addr] when MemRead=1, otherwise 0.
  - Contents are not affected by reset and initialise to 0 at time zero.
- Write-back value = MemToRegSel ? mem read data : alu_result.
- Simultaneous events:
  - A register write and a memory write in the same cycle both use the values present before the edge.
  - A read of a register written on the same edge returns the old value until after the edge; there is no internal bypass.
  - MemWrite and MemRead together: the read returns the old contents before the edge.
- Reset: while rst_n=0, all 32 registers clear to 0 immediately. With all registers 0, Zero = 1 for any register-register operation other than nor. Reset asserted mid-cycle aborts any pending write. Reset release takes effect at the next posedge.

Optional Feature:
DMRF_DEBUG_PORTS_EN:
- When defined, three extra outputs are added: alu_result[31:0], wb_data[31:0] and mem_rdata[31:0]. Each is a combinational copy of the corresponding internal net.
- When undefined, these ports do not exist; the functional behaviour is identical either way.

Test Plan:
- Reset: rst_n=0, then release; ALUOp=00, rs=1, rt=2, ALUsel=0 -> Zero=1 and alu_result=0.
- Immediate load: rs=0, SEin=16'h0014, ALUsel=1, ALUOp=00, Regsel=0, rt=5, RegWrite=1, one edge -> reg5=0x14; then rs=5, rt=5, ALUsel=0, ALUOp=10, FuncCode=6'b000010 (sub) -> Zero=1.
- Negative immediate: SEin=16'hFFEC, rs=0, ALUsel=1 -> alu_result=0xFFFFFFEC and Zero=0. Then ALUOp=10, FuncCode=1010 with rs holding 0x14 -> slt result 0 (0x14 < -20 is false).
- Memory round trip: reg5=0x14, reg6=0x55555555; rs=5, rt=6, SEin=0, ALUsel=1, MemWrite=1, edge -> mem word 5 = 0x55555555. Then MemRead=1, MemToRegSel=1, RegWrite=1, Regsel=1, rd=7, edge -> reg7=0x55555555.
- r0 protection: write 0x14 to rd=0 with Regsel=1, RegWrite=1 -> subsequent read of rs=0 returns 0 and add with imm 0 gives Zero=1.
- Async reset mid-operation: assert rst_n low between edges while RegWrite=1 -> registers read 0 immediately and no write occurs at the following edge while reset is held.
